items_eat_writer: RTL
=====================

// Module: items_eat_writer
// PURPOSE
//  Writer side of the items sprite RAM. When Pac-Man enters a pellet, it erases
//  a BLK x BLK pixel square of the items map by overwriting it with BG_COLOR.
//  It first reads each pixel to detect whether a pellet was present, so it also
//  reports eat events and keeps a running pellet count.
//  Sits between the game-logic FSM (eat requests) and the items RAM write port.
//  It borrows the RAM read port only while busy=1; the top-level mux grants that
//  port during vertical blanking.
// PARAMETERS
//  MAP_W     52        items map width in pixels
//  MAP_H     52        items map height in pixels (MAP_W*MAP_H <= 2**ADDR_W)
//  BLK       3         side of the erased square in pixels
//  BG_COLOR  24'h000000  colour written over eaten pixels; "empty" reference
//  ADDR_W    12        RAM address width
//  DATA_W    24        RAM pixel width (RGB888)
// PORTS
//  Clk           in   1       system clock, all logic on rising edge
//  Reset         in   1       asynchronous, active-high reset
//  eat_req       in   1       1-cycle pulse: erase square at (eat_x,eat_y)
//  eat_x         in   6       top-left x of square, map coordinates
//  eat_y         in   6       top-left y of square, map coordinates
//  vblank        in   1       high during vertical blanking; start permitted
//  ram_rdata     in   DATA_W  RAM data_Out (registered, 1-cycle read latency)
//  ram_raddr     out  ADDR_W  read address; top muxes it in while busy=1
//  ram_waddr     out  ADDR_W  write address to RAM
//  ram_wdata     out  DATA_W  write data to RAM (always BG_COLOR)
//  ram_we        out  1       RAM write enable
//  busy          out  1       high from start of first read to end of last check
//  done          out  1       1-cycle pulse when a square has been processed
//  pellet_eaten  out  1       valid with done: any pixel in square != BG_COLOR
//  eaten_count   out  8       number of done pulses with pellet_eaten=1; saturates at 255
// BEHAVIOUR
//  Reset (async): state=IDLE, pending=0; every output 0 except ram_wdata=BG_COLOR.
//  Pending slot (1 deep):
//   - eat_req sets pending and latches x/y.
//   - A later eat_req while pending overwrites x/y; the last request wins.
//   - eat_req while busy is latched as pending and serviced after done.
//   - eat_req in the same cycle as done is also latched.
//  FSM states: IDLE, WAIT_VB, RD, CHK, DONE.
//   IDLE:    pending & vblank -> RD; pending & !vblank -> WAIT_VB.
//   WAIT_VB: vblank -> RD. Leaving IDLE/WAIT_VB clears pending and resets dx=dy=0, hit=0.
//   RD:      ram_raddr = (y+dy)*MAP_W + (x+dx), computed at ADDR_W bits; busy=1; -> CHK.
//   CHK:     ram_rdata is valid for the RD address.
//     - In-bounds pixel with rdata != BG_COLOR: ram_we=1, ram_waddr = same address, hit=1.
//     - Otherwise: ram_we=0.
//     - Advance dx; when dx wraps at BLK-1, set dx=0 and dy++.
//     - Last pixel (dx=dy=BLK-1) -> DONE; else -> RD.
//   DONE:    done=1, pellet_eaten=hit, busy=0; eaten_count += hit (sat. 255); -> IDLE.
//  Clipping:
//   - A pixel with x+dx >= MAP_W or y+dy >= MAP_H is out of bounds.
//   - It still takes its RD/CHK slots, so latency stays fixed.
//   - For such a pixel: never written, does not set hit, ram_raddr = 0.
//  Latency: start edge = cycle 0 (first RD). Pixel k occupies RD cycle 2k and
//   CHK cycle 2k+1. done fires in cycle 2*BLK*BLK (18 for BLK=3). Max 1 write/cycle.
//  vblank falling mid-operation does not stall; the operation runs to completion
//   (the top level guarantees 18 cycles fit in blanking).
//  Reset mid-operation: ram_we drops immediately; pending and hit are lost.
//   Partially erased squares are acceptable.
// TESTING
//  1 Pellet at (10,10), 3x3 of 24'hFFB8AE, vblank=1, req -> 9 writes of BG to
//    addr 530..532, 582..584, 634..636; done at cycle 18; pellet_eaten=1; count=1.
//  2 Square already BG at (0,0) -> no ram_we during op; done with pellet_eaten=0;
//    count unchanged.
//  3 Req at (51,51) -> only addr 2703 is read/written; done still at cycle 18.
//  4 Req with vblank=0 for 40 cycles -> busy=0, no RAM access; vblank rises ->
//    start on next edge.
//  5 Two reqs during busy ((5,5), then (20,20)) -> only (20,20) is processed, and
//    it starts right after done.
//  6 Reset asserted in cycle 7 -> ram_we=0, busy=0 asynchronously; after release,
//    IDLE and count=0; 256 eaten squares -> count holds at 255.

Source files
------------

// File: rtl/items_eat_writer_if.sv
// Bundle between the eat writer, the game-logic FSM and the items sprite RAM.
// The slave modport is the writer's view; the master modport is its surroundings.
interface items_eat_writer_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 24
);
  logic              eat_req;
  logic [5:0]        eat_x;
  logic [5:0]        eat_y;
  logic              vblank;
  logic [DATA_W-1:0] ram_rdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              busy;
  logic              done;
  logic              pellet_eaten;
  logic [7:0]        eaten_count;

  modport master (
    output eat_req, eat_x, eat_y, vblank, ram_rdata,
    input  ram_raddr, ram_waddr, ram_wdata, ram_we, busy, done, pellet_eaten, eaten_count
  );

  modport slave (
    input  eat_req, eat_x, eat_y, vblank, ram_rdata,
    output ram_raddr, ram_waddr, ram_wdata, ram_we, busy, done, pellet_eaten, eaten_count
  );
endinterface

// File: rtl/items_eat_writer.sv
// Erases a BLK x BLK square of the items map with BG_COLOR, reading each pixel
// first to report whether a pellet was eaten and to keep a saturating eat count.
//
//  state   | meaning
//  IDLE    | no square in progress; waits for a pending request
//  WAIT_VB | request pending, waiting for vertical blanking
//  RD      | read address of current pixel presented to the RAM
//  CHK     | read data valid; overwrite pixel if it holds a pellet
//  DONE    | square finished; done pulse with pellet_eaten
module items_eat_writer #(
  parameter int              MAP_W    = 52,
  parameter int              MAP_H    = 52,
  parameter int              BLK      = 3,
  parameter logic [23:0]     BG_COLOR = 24'h000000,
  parameter int              ADDR_W   = 12,
  parameter int              DATA_W   = 24
) (
  input logic          clk,
  input logic          rst,
  items_eat_writer_if.slave bus
);

  localparam int CW = (BLK > 1) ? $clog2(BLK) : 1;

  typedef enum logic [2:0] {IDLE, WAIT_VB, RD, CHK, DONE} state_t;

  state_t            state;
  logic              pend;
  logic [5:0]        pend_x;
  logic [5:0]        pend_y;
  logic [5:0]        cur_x;
  logic [5:0]        cur_y;
  logic [CW-1:0]     dx;
  logic [CW-1:0]     dy;
  logic              hit;
  logic              inb;
  logic [ADDR_W-1:0] addr;
  logic              busy_q;
  logic              done_q;
  logic              pellet_q;
  logic [7:0]        count_q;

  logic [CW-1:0]     nx;
  logic [CW-1:0]     ny;
  logic              last;
  logic              wr;
  logic              start;
  logic [ADDR_W:0]   start_pix;
  logic [ADDR_W:0]   next_pix;

  // Returns {in_bounds, address}; out-of-bounds pixels map to address 0.
  function automatic logic [ADDR_W:0] pix_addr(input logic [5:0] bx, input logic [5:0] by,
                                               input logic [CW-1:0] ox, input logic [CW-1:0] oy);
    logic [7:0] px;
    logic [7:0] py;
    px = {2'b00, bx} + 8'(ox);
    py = {2'b00, by} + 8'(oy);
    if ((px < 8'(MAP_W)) && (py < 8'(MAP_H)))
      pix_addr = {1'b1, ADDR_W'(py) * ADDR_W'(MAP_W) + ADDR_W'(px)};
    else
      pix_addr = '0;
  endfunction

  always_comb begin
    if (dx == CW'(BLK - 1)) begin
      nx = '0;
      ny = dy + 1'b1;
    end else begin
      nx = dx + 1'b1;
      ny = dy;
    end
  end

  assign last      = (dx == CW'(BLK - 1)) && (dy == CW'(BLK - 1));
  assign start     = pend && bus.vblank && ((state == IDLE) || (state == WAIT_VB));
  assign start_pix = pix_addr(pend_x, pend_y, '0, '0);
  assign next_pix  = pix_addr(cur_x, cur_y, nx, ny);

  // Write strobe must follow the read data in the same cycle, so it is decoded
  // from state rather than registered; it also drops as soon as reset hits.
  assign wr = (state == CHK) && inb && (bus.ram_rdata != DATA_W'(BG_COLOR));

  assign bus.ram_we       = wr;
  assign bus.ram_raddr    = addr;
  assign bus.ram_waddr    = addr;
  assign bus.ram_wdata    = DATA_W'(BG_COLOR);
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.pellet_eaten = pellet_q;
  assign bus.eaten_count  = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pend     <= 1'b0;
      pend_x   <= '0;
      pend_y   <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      dx       <= '0;
      dy       <= '0;
      hit      <= 1'b0;
      inb      <= 1'b0;
      addr     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pellet_q <= 1'b0;
      count_q  <= '0;
    end else begin
      done_q <= 1'b0;

      // A new request always wins over the clear on start, so a request in the
      // start or done cycle is kept for the next square.
      if (bus.eat_req) begin
        pend   <= 1'b1;
        pend_x <= bus.eat_x;
        pend_y <= bus.eat_y;
      end else if (start) begin
        pend <= 1'b0;
      end

      case (state)
        IDLE, WAIT_VB: begin
          if (start) begin
            state  <= RD;
            cur_x  <= pend_x;
            cur_y  <= pend_y;
            dx     <= '0;
            dy     <= '0;
            hit    <= 1'b0;
            inb    <= start_pix[ADDR_W];
            addr   <= start_pix[ADDR_W-1:0];
            busy_q <= 1'b1;
          end else if (pend) begin
            state <= WAIT_VB;
          end
        end
        RD: state <= CHK;
        CHK: begin
          hit <= hit | wr;
          if (last) begin
            state    <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            pellet_q <= hit | wr;
            if ((hit | wr) && (count_q != 8'hFF))
              count_q <= count_q + 8'd1;
          end else begin
            state <= RD;
            dx    <= nx;
            dy    <= ny;
            inb   <= next_pix[ADDR_W];
            addr  <= next_pix[ADDR_W-1:0];
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
